keypad_entry: RTL

- Input front end for the arithmetic/logic calculator. Scans a 4x4 matrix keypad, debounces key presses, and assembles decimal operands and an operator.
- Drives the calculator's operand A, operand B, operation code and "equals" inputs, so the board needs no slide switches.
- The calculator computes on the falling edge of equals after it has been high. This block produces a multi-cycle equals pulse to match.

---
 rtl/keypad_pkg.sv | 34 +++
 rtl/keypad_scan.sv | 73 +++++++
 rtl/keypad_entry.sv | 94 +++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, keypad index map, operator map and entry states
package keypad_pkg;
   localparam logic [3:0] K_ADD = 4'd10;
   localparam logic [3:0] K_MUL = 4'd11;
   localparam logic [3:0] K_DIV = 4'd12;
   localparam logic [3:0] K_AND = 4'd13;
   localparam logic [3:0] K_OR  = 4'd14;
   localparam logic [3:0] K_EQ  = 4'd15;
   typedef enum logic [1:0] {ENTER_A, ENTER_B, RESULT} entry_state_t;
   function automatic logic [3:0] key_map(input logic [3:0] idx);
      case (idx)
         4'd0:  return 4'd1;
         4'd1:  return 4'd2;
         4'd2:  return 4'd3;
         4'd3:  return K_ADD;
         4'd4:  return 4'd4;
         4'd5:  return 4'd5;
         4'd6:  return 4'd6;
         4'd7:  return K_MUL;
         4'd8:  return 4'd7;
         4'd9:  return 4'd8;
         4'd10: return 4'd9;
         4'd11: return K_DIV;
         4'd12: return K_AND;
         4'd13: return 4'd0;
         4'd14: return K_OR;
         default: return K_EQ;
      endcase
   endfunction
   // operator codes 10..14 map onto do_opt 1..5 in the same order
   function automatic logic [2:0] op_map(input logic [3:0] code);
      return 3'(code - 4'd9);
   endfunction
endpackage

// File: rtl/keypad_scan.sv
// keypad_scan: row scanning, column sync, frame code and debounced key events
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV   = 1000,
   parameter int DEB_FRAMES = 4
) (
   input  logic       clk,
   input  logic       ac,
   input  logic [3:0] kp_col,
   output logic [3:0] kp_row,
   output logic       key_evt,
   output logic [3:0] key_code
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int SW = $clog2(DEB_FRAMES + 1);
   logic [3:0] col_m, col_s, pressed, hit_idx;
   logic [1:0] row, low_col;
   logic [DW-1:0] dwell;
   logic [SW-1:0] stab, stab_n;
   logic [4:0] prev, frame;
   logic hit, latched, sample, row_hit;
   assign kp_row = ~(4'b0001 << row);
   // frame is {valid, index}; "none" is all zeros so it compares cleanly
   always_comb begin
      sample  = dwell == DW'(SCAN_DIV - 1);
      pressed = ~col_s;
      low_col = pressed[0] ? 2'd0 : pressed[1] ? 2'd1 : pressed[2] ? 2'd2 : 2'd3;
      row_hit = !hit && |pressed;
      frame   = hit ? {1'b1, hit_idx} : |pressed ? {1'b1, row, low_col} : 5'd0;
      stab_n  = frame != prev ? SW'(1) : stab == SW'(DEB_FRAMES) ? stab : stab + SW'(1);
   end
   always_ff @(posedge clk) begin
      if (ac) begin
         col_m    <= 4'hF;
         col_s    <= 4'hF;
         row      <= '0;
         dwell    <= '0;
         hit      <= 1'b0;
         hit_idx  <= '0;
         prev     <= '0;
         stab     <= '0;
         latched  <= 1'b0;
         key_evt  <= 1'b0;
         key_code <= '0;
      end else begin
         col_m   <= kp_col;
         col_s   <= col_m;
         key_evt <= 1'b0;
         dwell   <= sample ? '0 : dwell + DW'(1);
         if (sample) begin
            row <= row + 2'd1;
            if (row == 2'd3) begin
               hit  <= 1'b0;
               prev <= frame;
               stab <= stab_n;
               if (stab_n == SW'(DEB_FRAMES)) begin
                  if (frame[4] && !latched) begin
                     key_evt  <= 1'b1;
                     key_code <= key_map(frame[3:0]);
                     latched  <= 1'b1;
                  end else if (!frame[4]) begin
                     latched <= 1'b0;
                  end
               end
            end else if (row_hit) begin
               hit     <= 1'b1;
               hit_idx <= {row, low_col};
            end
         end
      end
   end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: keypad front end assembling operands, operator and equals pulse
module keypad_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV   = 1000,
   parameter int DEB_FRAMES = 4,
   parameter int EQ_HOLD    = 4
) (
   input  logic       clk,
   input  logic       ac,
   input  logic [3:0] kp_col,
   output logic [3:0] kp_row,
   output logic [3:0] opt_a,
   output logic [3:0] opt_b,
   output logic [2:0] do_opt,
   output logic       equal_to,
   output logic       key_evt,
   output logic [3:0] key_code
);
   localparam int EW = $clog2(EQ_HOLD + 1);
   entry_state_t state, state_n;
   logic [3:0] a_n, b_n;
   logic [2:0] op_n;
   logic [7:0] acc_a, acc_b;
   logic [EW-1:0] eq_cnt, eq_n;
   logic is_digit, is_eq, eq_load;
   keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB_FRAMES)) u_scan (
      .clk      (clk),
      .ac       (ac),
      .kp_col   (kp_col),
      .kp_row   (kp_row),
      .key_evt  (key_evt),
      .key_code (key_code)
   );
   always_comb begin
      is_digit = key_code <= 4'd9;
      is_eq    = key_code == K_EQ;
      acc_a    = {4'd0, opt_a} * 8'd10 + {4'd0, key_code};
      acc_b    = {4'd0, opt_b} * 8'd10 + {4'd0, key_code};
      state_n  = state;
      a_n      = opt_a;
      b_n      = opt_b;
      op_n     = do_opt;
      eq_load  = 1'b0;
      if (key_evt) begin
         case (state)
            ENTER_A:
               if (is_digit) a_n = acc_a <= 8'd15 ? acc_a[3:0] : opt_a;
               else if (!is_eq) begin
                  op_n    = op_map(key_code);
                  b_n     = '0;
                  state_n = ENTER_B;
               end
            ENTER_B:
               if (is_digit) b_n = acc_b <= 8'd15 ? acc_b[3:0] : opt_b;
               else if (is_eq) begin
                  eq_load = 1'b1;
                  state_n = RESULT;
               end else op_n = op_map(key_code);
            RESULT:
               if (is_digit) begin
                  a_n     = key_code;
                  b_n     = '0;
                  op_n    = '0;
                  state_n = ENTER_A;
               end else if (is_eq) eq_load = 1'b1;
               else begin
                  op_n    = op_map(key_code);
                  b_n     = '0;
                  state_n = ENTER_B;
               end
            default: state_n = ENTER_A;
         endcase
      end
      eq_n = eq_load ? EW'(EQ_HOLD) : eq_cnt != '0 ? eq_cnt - EW'(1) : '0;
   end
   always_ff @(posedge clk) begin
      if (ac) begin
         state    <= ENTER_A;
         opt_a    <= '0;
         opt_b    <= '0;
         do_opt   <= '0;
         eq_cnt   <= '0;
         equal_to <= 1'b0;
      end else begin
         state    <= state_n;
         opt_a    <= a_n;
         opt_b    <= b_n;
         do_opt   <= op_n;
         eq_cnt   <= eq_n;
         equal_to <= eq_n != '0;
      end
   end
endmodule
